// File: rtl/punc_datapath.sv
// PUnC LC3 datapath: PC, IR, NZP flags and indirect store register, plus the
// ALU, immediate/offset sign-extension and the memory/register-file muxes.
module punc_datapath #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_ld,
   input  logic        pc_clr,
   input  logic        pc_inc,
   input  logic        pc_data_sel,
   input  logic        pc_add_sel,
   input  logic        ir_ld,
   input  logic [1:0]  addr_mem_sel,
   input  logic [1:0]  w_rf_sel,
   input  logic [1:0]  sext_sel,
   input  logic        a_sel,
   input  logic        b_sel,
   input  logic [1:0]  alu_sel,
   input  logic        nzp_sel,
   input  logic        n_ld,
   input  logic        z_ld,
   input  logic        p_ld,
   input  logic        store_ld,
   input  logic [15:0] rf_r0_data,
   input  logic [15:0] rf_r1_data,
   input  logic [15:0] mem_r_data,
   output logic [15:0] IR,
   output logic [15:0] pc,
   output logic        n,
   output logic        z,
   output logic        p,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_w_data,
   output logic [15:0] rf_w_data
);

   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] store_q, store_d;
   logic        n_q, n_d, z_q, z_d, p_q, p_d;
   logic [15:0] imm, pc_off, pc_target;
   logic [15:0] alu_a, alu_b, alu_result, flag_v;

   always_comb begin
      unique case (sext_sel)
         2'd0:    imm = {{11{ir_q[4]}}, ir_q[4:0]};
         2'd1:    imm = {{10{ir_q[5]}}, ir_q[5:0]};
         2'd2:    imm = {{7{ir_q[8]}},  ir_q[8:0]};
         default: imm = {{5{ir_q[10]}}, ir_q[10:0]};
      endcase

      pc_off    = pc_add_sel ? {{7{ir_q[8]}}, ir_q[8:0]} : {{5{ir_q[10]}}, ir_q[10:0]};
      pc_target = pc_q + pc_off;

      alu_a = a_sel ? rf_r0_data : pc_q;
      alu_b = b_sel ? imm : rf_r1_data;
      unique case (alu_sel)
         2'b00:   alu_result = alu_a + alu_b;
         2'b01:   alu_result = alu_a & alu_b;
         2'b10:   alu_result = alu_a;
         default: alu_result = ~alu_a;
      endcase

      unique case (addr_mem_sel)
         2'd1:    mem_addr = alu_result;
         2'd2:    mem_addr = store_q;
         default: mem_addr = pc_q;
      endcase

      unique case (w_rf_sel)
         2'd0:    rf_w_data = pc_q;
         2'd1:    rf_w_data = mem_r_data;
         default: rf_w_data = alu_result;
      endcase

      mem_w_data = rf_r1_data;
   end

   // Next-state for every register is computed from the same pre-edge values.
   always_comb begin
      pc_d = pc_q;
      if (pc_clr)
         pc_d = RESET_PC;
      else if (pc_ld)
         pc_d = pc_data_sel ? alu_result : pc_target;
      else if (pc_inc)
         pc_d = pc_q + 16'd1;

      ir_d    = ir_ld    ? mem_r_data : ir_q;
      store_d = store_ld ? mem_r_data : store_q;

      flag_v = nzp_sel ? mem_r_data : alu_result;
      n_d = n_ld ? flag_v[15] : n_q;
      z_d = z_ld ? (flag_v == 16'd0) : z_q;
      p_d = p_ld ? (!flag_v[15] && (flag_v != 16'd0)) : p_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ir_q    <= 16'd0;
         store_q <= 16'd0;
         n_q     <= 1'b0;
         z_q     <= 1'b1;
         p_q     <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         store_q <= store_d;
         n_q     <= n_d;
         z_q     <= z_d;
         p_q     <= p_d;
      end
   end

   assign IR = ir_q;
   assign pc = pc_q;
   assign n  = n_q;
   assign z  = z_q;
   assign p  = p_q;

endmodule

// File: tb/tb_punc_datapath.sv
// Scoreboard bench for punc_datapath: directed vectors push expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_punc_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_ld, pc_clr, pc_inc, pc_data_sel, pc_add_sel, ir_ld;
   logic [1:0]  addr_mem_sel, w_rf_sel, sext_sel, alu_sel;
   logic        a_sel, b_sel, nzp_sel, n_ld, z_ld, p_ld, store_ld;
   logic [15:0] rf_r0_data, rf_r1_data, mem_r_data;
   logic [15:0] IR, pc, mem_addr, mem_w_data, rf_w_data;
   logic        n, z, p;

   typedef enum int {SIG_PC, SIG_IR, SIG_N, SIG_Z, SIG_P, SIG_ADDR, SIG_MWD, SIG_RFW} sig_e;
   typedef struct {
      string       name;
      sig_e        sig;
      logic [15:0] exp;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   punc_datapath #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst),
      .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc),
      .pc_data_sel(pc_data_sel), .pc_add_sel(pc_add_sel), .ir_ld(ir_ld),
      .addr_mem_sel(addr_mem_sel), .w_rf_sel(w_rf_sel), .sext_sel(sext_sel),
      .a_sel(a_sel), .b_sel(b_sel), .alu_sel(alu_sel), .nzp_sel(nzp_sel),
      .n_ld(n_ld), .z_ld(z_ld), .p_ld(p_ld), .store_ld(store_ld),
      .rf_r0_data(rf_r0_data), .rf_r1_data(rf_r1_data), .mem_r_data(mem_r_data),
      .IR(IR), .pc(pc), .n(n), .z(z), .p(p),
      .mem_addr(mem_addr), .mem_w_data(mem_w_data), .rf_w_data(rf_w_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] getSig(input sig_e s);
      case (s)
         SIG_PC:   return pc;
         SIG_IR:   return IR;
         SIG_N:    return {15'd0, n};
         SIG_Z:    return {15'd0, z};
         SIG_P:    return {15'd0, p};
         SIG_ADDR: return mem_addr;
         SIG_MWD:  return mem_w_data;
         default:  return rf_w_data;
      endcase
   endfunction

   // Monitor: everything queued since the last falling edge is compared now.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [15:0] act;
         e   = sb.pop_front();
         act = getSig(e.sig);
         compared++;
         if (act !== e.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic checkOutput(input string name, input sig_e sig, input logic [15:0] exp);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic clearControls();
      pc_ld = 0; pc_clr = 0; pc_inc = 0; pc_data_sel = 0; pc_add_sel = 0; ir_ld = 0;
      addr_mem_sel = 0; w_rf_sel = 0; sext_sel = 0; alu_sel = 0;
      a_sel = 0; b_sel = 0; nzp_sel = 0; n_ld = 0; z_ld = 0; p_ld = 0; store_ld = 0;
      rf_r0_data = 0; rf_r1_data = 0; mem_r_data = 0;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      clearControls();
   endtask

   task automatic setPc(input logic [15:0] v);
      pc_ld = 1; pc_data_sel = 1; a_sel = 1; alu_sel = 2'b10; rf_r0_data = v;
      applyStimulus();
   endtask

   task automatic loadIr(input logic [15:0] v);
      mem_r_data = v; ir_ld = 1;
      applyStimulus();
   endtask

   task automatic checkFlags(input string tag, input logic en, input logic ez, input logic ep);
      checkOutput({tag, "_n"}, SIG_N, {15'd0, en});
      checkOutput({tag, "_z"}, SIG_Z, {15'd0, ez});
      checkOutput({tag, "_p"}, SIG_P, {15'd0, ep});
   endtask

   initial begin
      clearControls();
      #2 rst = 1;
      checkOutput("rst0_pc", SIG_PC, 16'h0000);
      checkOutput("rst0_ir", SIG_IR, 16'h0000);
      checkFlags("rst0", 0, 1, 0);
      @(posedge clk); #1 rst = 0;

      // Fetch
      mem_r_data = 16'h1261; ir_ld = 1; pc_inc = 1;
      applyStimulus();
      checkOutput("fetch_ir", SIG_IR, 16'h1261);
      checkOutput("fetch_pc", SIG_PC, 16'h0001);

      // Asynchronous reset mid-cycle
      applyStimulus();
      #2 rst = 1;
      checkOutput("arst_pc", SIG_PC, 16'h0000);
      checkOutput("arst_ir", SIG_IR, 16'h0000);
      checkFlags("arst", 0, 1, 0);
      @(posedge clk); #1 rst = 0;

      loadIr(16'h1261);
      nzp_sel = 1; mem_r_data = 16'h8000; n_ld = 1; z_ld = 1; p_ld = 1;
      applyStimulus();
      checkFlags("memneg", 1, 0, 0);

      // ADD immediate: FFFF + 1 wraps to zero
      rf_r0_data = 16'hFFFF; a_sel = 1; b_sel = 1; sext_sel = 0; alu_sel = 2'b00;
      w_rf_sel = 2; n_ld = 1; z_ld = 1; p_ld = 1;
      checkOutput("addimm_rfw", SIG_RFW, 16'h0000);
      applyStimulus();
      checkFlags("addimm", 0, 1, 0);

      // Only p_ld: n and z must hold
      rf_r0_data = 16'h0005; a_sel = 1; alu_sel = 2'b10; w_rf_sel = 3; p_ld = 1;
      checkOutput("pass_rfw", SIG_RFW, 16'h0005);
      applyStimulus();
      checkFlags("ponly", 0, 1, 1);

      rf_r0_data = 16'hF0F0; rf_r1_data = 16'h3CCC; a_sel = 1; alu_sel = 2'b01; w_rf_sel = 2;
      checkOutput("and_rfw", SIG_RFW, 16'h30C0);
      checkOutput("mem_w_data", SIG_MWD, 16'h3CCC);
      applyStimulus();
      rf_r0_data = 16'hF0F0; a_sel = 1; alu_sel = 2'b11; w_rf_sel = 2;
      checkOutput("not_rfw", SIG_RFW, 16'h0F0F);
      applyStimulus();

      // Immediate widths from IR = 1261
      a_sel = 1; b_sel = 1; sext_sel = 1; w_rf_sel = 2;
      checkOutput("sext6_rfw", SIG_RFW, 16'hFFE1);
      applyStimulus();
      a_sel = 1; b_sel = 1; sext_sel = 2; w_rf_sel = 2;
      checkOutput("sext9_rfw", SIG_RFW, 16'h0061);
      applyStimulus();
      a_sel = 1; b_sel = 1; sext_sel = 3; w_rf_sel = 2;
      checkOutput("sext11_rfw", SIG_RFW, 16'h0261);
      applyStimulus();

      // Branch with negative offset9, then PC increment wrap
      setPc(16'h0005);
      loadIr(16'h0FFE);
      pc_ld = 1; pc_add_sel = 1;
      applyStimulus();
      checkOutput("br_pc", SIG_PC, 16'h0003);
      setPc(16'hFFFF);
      pc_inc = 1;
      applyStimulus();
      checkOutput("inc_wrap_pc", SIG_PC, 16'h0000);

      // LDI: PC-relative pointer, then indirect address from store reg
      setPc(16'h0010);
      loadIr(16'hA002);
      addr_mem_sel = 1; sext_sel = 2; b_sel = 1; alu_sel = 2'b00;
      mem_r_data = 16'h3000; store_ld = 1;
      checkOutput("ldi_addr1", SIG_ADDR, 16'h0012);
      applyStimulus();
      addr_mem_sel = 2; mem_r_data = 16'h8000; nzp_sel = 1; n_ld = 1; z_ld = 1; p_ld = 1;
      checkOutput("ldi_addr2", SIG_ADDR, 16'h3000);
      applyStimulus();
      checkFlags("ldi", 1, 0, 0);
      addr_mem_sel = 0;
      checkOutput("addr_sel0", SIG_ADDR, 16'h0010);
      applyStimulus();
      addr_mem_sel = 3;
      checkOutput("addr_sel3", SIG_ADDR, 16'h0010);
      applyStimulus();

      // PC priority: clear beats load beats increment
      pc_clr = 1; pc_ld = 1; pc_inc = 1;
      applyStimulus();
      checkOutput("prio_clr_pc", SIG_PC, 16'h0000);
      pc_ld = 1; pc_inc = 1; pc_data_sel = 1; a_sel = 1; alu_sel = 2'b10; rf_r0_data = 16'h0040;
      applyStimulus();
      checkOutput("prio_ld_pc", SIG_PC, 16'h0040);

      // JSR: link value is the pre-update PC
      loadIr(16'h4805);
      pc_ld = 1; pc_data_sel = 0; pc_add_sel = 0; w_rf_sel = 0;
      checkOutput("jsr_link", SIG_RFW, 16'h0040);
      applyStimulus();
      checkOutput("jsr_pc", SIG_PC, 16'h0045);

      // Offset select: IR = 0601 gives +1 (offset9) or -0x1FF (offset11)
      loadIr(16'h0601);
      pc_ld = 1; pc_add_sel = 1;
      applyStimulus();
      checkOutput("off9_pc", SIG_PC, 16'h0046);
      pc_ld = 1; pc_add_sel = 0;
      applyStimulus();
      checkOutput("off11_pc", SIG_PC, 16'hFE47);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
